phy_deskew_trainer: RTL and testbench

//  Per-lane DCDL delay trainer for the RX data lanes. On start, sweeps the DCDL code over its full

---
 rtl/phy_deskew_trainer.sv | 192 +++++++++++++++++++
 tb/tb_phy_deskew_trainer.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/phy_deskew_trainer.sv
// Per-lane DCDL delay trainer: sweeps every code on all enabled lanes in parallel and parks
// each lane at the floor midpoint of its widest window where the training word was received.
module phy_deskew_trainer #(
    parameter int LANES         = 16,
    parameter int DATA_W        = 32,
    parameter int DL_CTRL_BITS  = 6,
    parameter int SETTLE_CYCLES = 8,
    parameter int SAMPLES       = 4,
    parameter int MIN_EYE       = 4,
    parameter int DEFAULT_CODE  = 32
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             start,
    input  logic                             abort,
    input  logic [LANES-1:0]                 lane_en,
    input  logic [DATA_W-1:0]                pattern,
    input  logic [LANES*DATA_W-1:0]          rx_dout,
    output logic [LANES*DL_CTRL_BITS-1:0]    dl_ctrl,
    output logic                             busy,
    output logic                             done,
    output logic [LANES-1:0]                 lane_pass,
    output logic [LANES*(DL_CTRL_BITS+1)-1:0] eye_width
);

    localparam int CW       = DL_CTRL_BITS;
    localparam int LW       = DL_CTRL_BITS + 1;
    localparam int CNT_MAX  = (SETTLE_CYCLES > SAMPLES) ? SETTLE_CYCLES : SAMPLES;
    localparam int CNT_W    = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CW-1:0]    CODE_MAX    = {CW{1'b1}};
    localparam logic [CW-1:0]    DEF_CODE    = CW'(DEFAULT_CODE);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] SAMPLE_LAST = CNT_W'(SAMPLES - 1);

    typedef enum logic [2:0] {IDLE, SETTLE, SAMPLE, NEXT, CENTER, DONE} state_t;

    state_t            state, state_next;
    logic [CNT_W-1:0]  cnt;
    logic [CW-1:0]     code;
    logic [LANES-1:0]  en_q;
    logic [LANES-1:0]  pass_acc;
    logic [LANES-1:0]  match;
    logic              sweeping;

    logic [LW-1:0]     run_len    [LANES];
    logic [LW-1:0]     run_inc    [LANES];
    logic [LW-1:0]     best_len   [LANES];
    logic [LW-1:0]     best_start [LANES];
    logic [LW-1:0]     mid        [LANES];
    logic [CW-1:0]     res_dl     [LANES];

    // State register; abort overrides everything including a coincident start.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else if (abort) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = SETTLE;
            SETTLE:  if (cnt == SETTLE_LAST) state_next = SAMPLE;
            SAMPLE:  if (cnt == SAMPLE_LAST) state_next = NEXT;
            NEXT:    state_next = (code == CODE_MAX) ? CENTER : SETTLE;
            CENTER:  state_next = DONE;
            DONE:    if (start) state_next = SETTLE;
            default: state_next = IDLE;
        endcase
    end

    // The rotated compare absorbs the 1-UI word-alignment ambiguity of the deserialiser.
    always_comb begin
        match = '0;
        for (int i = 0; i < LANES; i++) begin
            match[i] = (rx_dout[i*DATA_W +: DATA_W] == pattern) ||
                       (rx_dout[i*DATA_W +: DATA_W] == {pattern[DATA_W-2:0], pattern[DATA_W-1]});
        end
    end

    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            run_inc[i] = run_len[i] + LW'(1);
            mid[i]     = best_start[i] + ((best_len[i] - LW'(1)) >> 1);
        end
    end

    // Sweep datapath. The best window is tracked while a run grows, so a run that reaches
    // the top code is already closed by the time CENTER reads it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt       <= '0;
            code      <= '0;
            en_q      <= '0;
            pass_acc  <= '0;
            lane_pass <= '0;
            eye_width <= '0;
            for (int i = 0; i < LANES; i++) begin
                run_len[i]    <= '0;
                best_len[i]   <= '0;
                best_start[i] <= '0;
                res_dl[i]     <= DEF_CODE;
            end
        end else if (abort) begin
            cnt       <= '0;
            code      <= '0;
            en_q      <= '0;
            pass_acc  <= '0;
            lane_pass <= '0;
            eye_width <= '0;
            for (int i = 0; i < LANES; i++) begin
                run_len[i]    <= '0;
                best_len[i]   <= '0;
                best_start[i] <= '0;
                res_dl[i]     <= DEF_CODE;
            end
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        cnt       <= '0;
                        code      <= '0;
                        en_q      <= lane_en;
                        lane_pass <= '0;
                        eye_width <= '0;
                        for (int i = 0; i < LANES; i++) begin
                            run_len[i]    <= '0;
                            best_len[i]   <= '0;
                            best_start[i] <= '0;
                            res_dl[i]     <= DEF_CODE;
                        end
                    end
                end
                SETTLE: begin
                    if (cnt == SETTLE_LAST) begin
                        cnt      <= '0;
                        pass_acc <= '1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                SAMPLE: begin
                    pass_acc <= pass_acc & match;
                    cnt      <= (cnt == SAMPLE_LAST) ? '0 : cnt + CNT_W'(1);
                end
                NEXT: begin
                    for (int i = 0; i < LANES; i++) begin
                        if (pass_acc[i]) begin
                            run_len[i] <= run_inc[i];
                            if (run_inc[i] > best_len[i]) begin
                                best_len[i]   <= run_inc[i];
                                best_start[i] <= {1'b0, code} - run_len[i];
                            end
                        end else begin
                            run_len[i] <= '0;
                        end
                    end
                    if (code != CODE_MAX) begin
                        code <= code + CW'(1);
                    end
                end
                CENTER: begin
                    for (int i = 0; i < LANES; i++) begin
                        eye_width[i*LW +: LW] <= en_q[i] ? best_len[i] : '0;
                        lane_pass[i]          <= en_q[i] && (best_len[i] >= LW'(MIN_EYE));
                        res_dl[i]             <= (en_q[i] && (best_len[i] >= LW'(MIN_EYE)))
                                                 ? mid[i][CW-1:0] : DEF_CODE;
                    end
                end
                default: ;
            endcase
        end
    end

    assign sweeping = (state == SETTLE) || (state == SAMPLE) || (state == NEXT) || (state == CENTER);

    // Enabled lanes follow the sweep code; otherwise the held result (or default) is driven.
    always_comb begin
        busy    = sweeping;
        done    = (state == DONE);
        dl_ctrl = '0;
        for (int i = 0; i < LANES; i++) begin
            dl_ctrl[i*CW +: CW] = (sweeping && en_q[i]) ? code : res_dl[i];
        end
    end

endmodule

// File: tb/tb_phy_deskew_trainer.sv
// Directed bench for phy_deskew_trainer: each lane model returns the training word only for
// DCDL codes inside programmed windows, and results are compared against hand-computed values.
module tb_phy_deskew_trainer;

    localparam int LANES = 4;
    localparam int DW    = 16;
    localparam int CW    = 4;
    localparam int LW    = 5;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 start;
    logic                 abort;
    logic [LANES-1:0]     lane_en;
    logic [DW-1:0]        pattern;
    logic [LANES*DW-1:0]  rx_dout;
    logic [LANES*CW-1:0]  dl_ctrl;
    logic                 busy;
    logic                 done;
    logic [LANES-1:0]     lane_pass;
    logic [LANES*LW-1:0]  eye_width;

    int asserts  = 0;
    int failures = 0;

    logic [CW-1:0] lo0 [LANES];
    logic [CW-1:0] hi0 [LANES];
    logic [CW-1:0] lo1 [LANES];
    logic [CW-1:0] hi1 [LANES];
    logic          rot [LANES];
    logic          gl  [LANES];
    logic [31:0]   cyc = '0;

    int            cycles;
    logic          first_busy;
    logic [15:0]   mid_dl;

    phy_deskew_trainer #(
        .LANES(LANES), .DATA_W(DW), .DL_CTRL_BITS(CW), .SETTLE_CYCLES(2),
        .SAMPLES(2), .MIN_EYE(3), .DEFAULT_CODE(8)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .lane_en(lane_en),
        .pattern(pattern), .rx_dout(rx_dout), .dl_ctrl(dl_ctrl), .busy(busy),
        .done(done), .lane_pass(lane_pass), .eye_width(eye_width)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // A glitching lane returns garbage on every other cycle at code 7, so one of the two
    // sampled words there is bad.
    function automatic logic [DW-1:0] lane_word(input logic [CW-1:0] c, input logic [CW-1:0] la,
                                                input logic [CW-1:0] ha, input logic [CW-1:0] lb,
                                                input logic [CW-1:0] hb, input logic r,
                                                input logic g, input logic odd,
                                                input logic [DW-1:0] p);
        logic inwin;
        inwin = ((c >= la) && (c <= ha)) || ((c >= lb) && (c <= hb));
        if (g && (c == 4'd7) && odd) return '0;
        if (!inwin) return ~p;
        return r ? {p[DW-2:0], p[DW-1]} : p;
    endfunction

    always_comb begin
        rx_dout = '0;
        for (int i = 0; i < LANES; i++) begin
            rx_dout[i*DW +: DW] = lane_word(dl_ctrl[i*CW +: CW], lo0[i], hi0[i], lo1[i], hi1[i],
                                            rot[i], gl[i], cyc[0], pattern);
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        asserts++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic checkLane(input string run, input int i, input int eye, input logic pass,
                             input int dl);
        checkOutput($sformatf("%s_l%0d_eye", run, i), 32'(eye_width[i*LW +: LW]), 32'(eye));
        checkOutput($sformatf("%s_l%0d_pass", run, i), 32'(lane_pass[i]), 32'(pass));
        checkOutput($sformatf("%s_l%0d_dl", run, i), 32'(dl_ctrl[i*CW +: CW]), 32'(dl));
    endtask

    task automatic checkIdle(input string run);
        checkOutput({run, "_dl"}, 32'(dl_ctrl), 32'h8888);
        checkOutput({run, "_busy"}, 32'(busy), 32'd0);
        checkOutput({run, "_done"}, 32'(done), 32'd0);
        checkOutput({run, "_pass"}, 32'(lane_pass), 32'd0);
        checkOutput({run, "_eye"}, 32'(eye_width), 32'd0);
    endtask

    task automatic setLane(input int i, input int la, input int ha, input int lb, input int hb,
                           input logic r, input logic g);
        lo0[i] = CW'(la); hi0[i] = CW'(ha); lo1[i] = CW'(lb); hi1[i] = CW'(hb);
        rot[i] = r; gl[i] = g;
    endtask

    task automatic configRun1();
        setLane(0, 5, 10, 15, 0, 1'b0, 1'b0);
        setLane(1, 1, 3, 9, 14, 1'b0, 1'b0);
        setLane(2, 0, 15, 15, 0, 1'b0, 1'b0);
        setLane(3, 2, 3, 15, 0, 1'b0, 1'b0);
    endtask

    // Pulses start and waits (bounded) for done; optionally re-pulses start mid-sweep.
    task automatic applyStimulus(input logic [3:0] en, input int busy_start_at);
        @(negedge clk);
        lane_en    = en;
        start      = 1'b1;
        cycles     = 0;
        first_busy = 1'b0;
        mid_dl     = '0;
        while (cycles < 300) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            cycles++;
            if (cycles == 1) first_busy = busy;
            if (cycles == 40) mid_dl = dl_ctrl;
            if (done) break;
            if (cycles == busy_start_at) start = 1'b1;
        end
    endtask

    task automatic checkRun1(input string run);
        checkOutput({run, "_latency"}, 32'(cycles), 32'd82);
        checkOutput({run, "_busy_first"}, 32'(first_busy), 32'd1);
        checkOutput({run, "_mid_dl"}, 32'(mid_dl), 32'h7777);
        checkOutput({run, "_busy_end"}, 32'(busy), 32'd0);
        checkOutput({run, "_dl_all"}, 32'(dl_ctrl), 32'h87B7);
        checkLane(run, 0, 6, 1'b1, 7);
        checkLane(run, 1, 6, 1'b1, 11);
        checkLane(run, 2, 16, 1'b1, 7);
        checkLane(run, 3, 2, 1'b0, 8);
    endtask

    initial begin
        reset   = 1'b1;
        start   = 1'b0;
        abort   = 1'b0;
        lane_en = '0;
        pattern = 16'hA5C3;
        for (int i = 0; i < LANES; i++) setLane(i, 15, 0, 15, 0, 1'b0, 1'b0);
        #12;
        checkIdle("reset");
        @(negedge clk);
        reset = 1'b0;

        configRun1();
        applyStimulus(4'hF, 0);
        checkRun1("run1");

        repeat (5) @(negedge clk);
        checkOutput("hold_dl", 32'(dl_ctrl), 32'h87B7);
        checkOutput("hold_done", 32'(done), 32'd1);

        applyStimulus(4'hF, 10);
        checkRun1("restart");

        setLane(0, 5, 10, 15, 0, 1'b1, 1'b1);
        setLane(1, 2, 5, 10, 13, 1'b0, 1'b0);
        setLane(2, 12, 15, 15, 0, 1'b0, 1'b0);
        setLane(3, 0, 15, 15, 0, 1'b0, 1'b0);
        applyStimulus(4'b0111, 0);
        checkOutput("run2_latency", 32'(cycles), 32'd82);
        checkOutput("run2_mid_dl", 32'(mid_dl), 32'h8777);
        checkLane("run2", 0, 3, 1'b1, 9);
        checkLane("run2", 1, 4, 1'b1, 3);
        checkLane("run2", 2, 4, 1'b1, 13);
        checkLane("run2", 3, 0, 1'b0, 8);

        configRun1();
        @(negedge clk);
        lane_en = 4'hF;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (30) @(negedge clk);
        checkOutput("pre_reset_busy", 32'(busy), 32'd1);
        #2 reset = 1'b1;
        #1;
        checkIdle("midreset");
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("post_reset_busy", 32'(busy), 32'd0);

        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        checkOutput("pre_abort_dl", 32'(dl_ctrl), 32'h4444);
        abort = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        start = 1'b0;
        checkIdle("abort");
        @(posedge clk);
        #1;
        checkOutput("post_abort_busy", 32'(busy), 32'd0);

        applyStimulus(4'hF, 0);
        checkRun1("after_abort");

        $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
        $finish;
    end

endmodule
